ysyx_24100006_ifu_fetch: RTL
============================

Name: ysyx_24100006_ifu_fetch

Overview:
IF-stage fetch engine; consumer of the PC register output.
- Takes a PC, issues one AXI4-Lite read for the instruction word, and returns the instruction to the IDU side.
- Produces the 2-bit fault code that feeds back into the PC register's fault mux, and the fetch-done pulse used as that register's write enable.
- One outstanding fetch at a time.

Parameters:
ADDR_W, 32, address and PC width
DATA_W, 32, instruction/rdata width
TIMEOUT_CYC, 1023, max cycles waiting in AR or R before a bus-timeout fault; 0 disables the watchdog

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
pc  input  ADDR_W  fetch address from PC register
in_valid  input  1  pc is valid, request a fetch
in_ready  output  1  fetch accepted this cycle
flush  input  1  redirect; discard current/pending fetch
out_valid  output  1  inst/out_pc/access_fault valid to IDU
out_ready  input  1  IDU accepts result
inst  output  DATA_W  fetched instruction (0 on fault)
out_pc  output  ADDR_W  PC of returned instruction
access_fault  output  2  00 ok, 01 bus error/timeout, 10 misaligned/decode error
pc_wen  output  1  one-cycle pulse on result handshake; drives PC register write enable
araddr  output  ADDR_W  AXI read address
arvalid  output  1  AXI AR valid
arready  input  1  AXI AR ready
rdata  input  DATA_W  AXI read data
rresp  input  2  AXI read response
rvalid  input  1  AXI R valid
rready  output  1  AXI R ready

Behaviour:
- Clock/reset: single clock clk; reset is synchronous, active-high, sampled on the rising edge of clk.
- Reset state: IDLE. Reset values: in_ready=0, out_valid=0, arvalid=0, rready=0, pc_wen=0, inst=0, out_pc=0, access_fault=00, drop flag=0, watchdog=0.
- States: IDLE, AR, R, HOLD.
- IDLE:
  - in_ready=1 unless flush=1.
  - On in_valid&&in_ready, latch pc into out_pc/araddr.
  - pc[1:0]!=0: go to HOLD with access_fault=10, inst=0, no bus access.
  - Otherwise go to AR.
- AR:
  - arvalid=1 with araddr stable until arready.
  - arvalid&&arready: go to R. Earliest R entry is the cycle after acceptance.
- R:
  - rready=1. On rvalid, capture rdata and map rresp: 00/01→00, 10→01, 11→10. inst=0 when fault≠00. Go to HOLD.
  - Minimum latency from accept to out_valid: 3 cycles with zero-wait bus (IDLE→AR→R→HOLD).
- HOLD:
  - out_valid=1, outputs stable until out_ready.
  - out_valid&&out_ready: pc_wen=1 for exactly that cycle; return to IDLE. Next accept earliest the following cycle.
- Flush:
  - In IDLE: no effect except in_ready=0 for that cycle.
  - In AR or R: arvalid is not withdrawn (AXI rule). Set drop flag, complete the handshake, discard the response (no out_valid, no pc_wen), return to IDLE.
  - In HOLD: out_valid drops next cycle, no pc_wen, go to IDLE.
  - flush and out_ready in the same HOLD cycle: flush wins, no pc_wen.
- Watchdog:
  - Counts cycles spent in AR+R and clears on state entry from IDLE.
  - At TIMEOUT_CYC (if nonzero): deassert arvalid/rready and go to HOLD with fault 01, inst=0.
  - A late rvalid afterwards is ignored, with rready=0 outside R. Bus recovery is not this block's responsibility.
- Reset mid-operation: return to IDLE next edge regardless of state; bus peers share the same reset.
- Simultaneous rvalid and watchdog expiry in the same cycle: rvalid wins.

Decomposition:
- Shared package ysyx_24100006_ifu_pkg holds:
  - state encoding (IDLE/AR/R/HOLD);
  - fault codes FAULT_NONE=2'b00, FAULT_BUS=2'b01, FAULT_ADDR=2'b10;
  - AXI resp constants OKAY/EXOKAY/SLVERR/DECERR.
- Fault codes must match the PC register's fault-select encoding.
- One sub-module is natural: ysyx_24100006_ifu_wdog, a clearable saturating counter with a terminal-count output, parameterized by TIMEOUT_CYC.

Test Plan:
- Basic fetch: pc=0x30000000, zero-wait bus returns rdata=0x00000413, rresp=00 → out_valid 3 cycles after accept; inst=0x00000413, out_pc=0x30000000, access_fault=00; pc_wen pulse on out_ready.
- Backpressure: arready delayed 4 cycles, rvalid delayed 5 cycles, out_ready held low 3 cycles → araddr/arvalid stable throughout; outputs stable in HOLD; single pc_wen pulse.
- Faults: rresp=10 → access_fault=01, inst=0; rresp=11 → 10; pc=0x30000002 → 10 with arvalid never asserted.
- Flush during R: flush pulses while waiting, rvalid arrives 2 cycles later → response consumed, no out_valid, no pc_wen; in_ready=1 on the next IDLE cycle.
- Timeout: TIMEOUT_CYC=8, rvalid never asserted → out_valid with access_fault=01 after 8 cycles in AR+R; a later rvalid is not consumed.
- Reset in R: reset asserted mid-fetch → next cycle IDLE, all outputs at reset values; a fresh fetch completes normally.

Source files
------------

// File: rtl/ysyx_24100006_ifu_pkg.sv
// Shared definitions for the IF-stage fetch engine: FSM state encoding,
// fault codes used by the PC register's fault mux, and AXI response codes.
package ysyx_24100006_ifu_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AR   = 2'd1;
    localparam logic [1:0] S_R    = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    // Must stay in sync with the PC register's fault-select encoding.
    localparam logic [1:0] FAULT_NONE = 2'b00;
    localparam logic [1:0] FAULT_BUS  = 2'b01;
    localparam logic [1:0] FAULT_ADDR = 2'b10;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    function automatic logic [1:0] resp_to_fault(input logic [1:0] resp);
        logic [1:0] fault;
        case (resp)
            SLVERR:  fault = FAULT_BUS;
            DECERR:  fault = FAULT_ADDR;
            default: fault = FAULT_NONE;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/ysyx_24100006_ifu_wdog.sv
// Clearable saturating cycle counter; tc flags the last allowed bus-wait cycle.
// TIMEOUT_CYC = 0 disables the terminal count entirely.
module ysyx_24100006_ifu_wdog #(
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam bit ENABLED = (TIMEOUT_CYC > 0);
    localparam int CNT_W   = ENABLED ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_SAT  = ENABLED ? CNT_W'(TIMEOUT_CYC) : '0;
    localparam logic [CNT_W-1:0] CNT_LAST = ENABLED ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset || clr) begin
            cnt <= '0;
        end else if (en && (cnt != CNT_SAT)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // cnt holds the number of enabled cycles already spent, so the cycle
    // with cnt == TIMEOUT_CYC-1 is the TIMEOUT_CYC-th one.
    assign tc = ENABLED && en && (cnt >= CNT_LAST);

endmodule

// File: rtl/ysyx_24100006_ifu_fetch.sv
// IF-stage fetch engine: one AXI4-Lite read per accepted PC, returns the
// instruction word plus a fault code, and pulses pc_wen on result handshake.
module ysyx_24100006_ifu_fetch
    import ysyx_24100006_ifu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic [1:0]        access_fault,
    output logic              pc_wen,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready
);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              drop;
    logic              drop_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] inst_q;
    logic [1:0]        fault_q;

    logic              accept;
    logic              misaligned;
    logic              discard;
    logic              wd_tc;
    logic [1:0]        r_fault;

    logic              res_load;
    logic [DATA_W-1:0] res_inst;
    logic [1:0]        res_fault;

    assign in_ready   = !reset && (state == S_IDLE) && !flush;
    assign accept     = in_valid && in_ready;
    assign misaligned = (pc[1:0] != 2'b00);
    assign discard    = drop || flush;
    assign r_fault    = resp_to_fault(rresp);

    assign arvalid   = (state == S_AR);
    assign rready    = (state == S_R);
    assign out_valid = (state == S_HOLD);
    // flush beats out_ready: a redirected result must never update the PC.
    assign pc_wen    = !reset && out_valid && out_ready && !flush;

    assign araddr       = addr_q;
    assign out_pc       = addr_q;
    assign inst         = inst_q;
    assign access_fault = fault_q;

    ysyx_24100006_ifu_wdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wdog (
        .clk  (clk),
        .reset(reset),
        .clr  (accept),
        .en   ((state == S_AR) || (state == S_R)),
        .tc   (wd_tc)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_nxt = state;
        drop_nxt  = drop;
        res_load  = 1'b0;
        res_inst  = '0;
        res_fault = FAULT_NONE;

        case (state)
            S_IDLE: begin
                drop_nxt = 1'b0;
                if (accept) begin
                    res_load  = 1'b1;
                    res_fault = misaligned ? FAULT_ADDR : FAULT_NONE;
                    state_nxt = misaligned ? S_HOLD : S_AR;
                end
            end

            S_AR: begin
                if (flush) drop_nxt = 1'b1;
                // The watchdog overrides a same-cycle arready; the late
                // response is never consumed since rready stays low.
                if (wd_tc) begin
                    res_load  = !discard;
                    res_fault = FAULT_BUS;
                    state_nxt = discard ? S_IDLE : S_HOLD;
                end else if (arready) begin
                    state_nxt = S_R;
                end
            end

            S_R: begin
                if (flush) drop_nxt = 1'b1;
                if (rvalid) begin
                    res_load  = !discard;
                    res_fault = r_fault;
                    res_inst  = (r_fault == FAULT_NONE) ? rdata : '0;
                    state_nxt = discard ? S_IDLE : S_HOLD;
                end else if (wd_tc) begin
                    res_load  = !discard;
                    res_fault = FAULT_BUS;
                    state_nxt = discard ? S_IDLE : S_HOLD;
                end
            end

            S_HOLD: begin
                if (flush || out_ready) state_nxt = S_IDLE;
            end

            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            drop    <= 1'b0;
            addr_q  <= '0;
            inst_q  <= '0;
            fault_q <= FAULT_NONE;
        end else begin
            state <= state_nxt;
            drop  <= drop_nxt;
            if (accept) addr_q <= pc;
            if (res_load) begin
                inst_q  <= res_inst;
                fault_q <= res_fault;
            end
        end
    end

endmodule
